// File: rtl/morse_capture_ctrl.sv
// Morse receive sequencer: unit-tick prescaler, capture re-arm FSM and output FIFO.
// Define MORSE_CTRL_AUTOSPACE_EN to push a space code after every word gap.
`ifndef CHAR_CODE_SPACE
`define CHAR_CODE_SPACE 5'h1E
`endif

module morse_capture_ctrl #(
  parameter int unsigned       PULSES_PER_UNIT = 4,
  parameter int unsigned       CHAR_W          = 5,
  parameter logic [CHAR_W-1:0] ERR_CODE        = 5'h1F,
  parameter int unsigned       FIFO_DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              cap_start,
  output logic              cap_ce,
  input  logic              cap_ceo,
  input  logic              cap_char_end,
  input  logic              cap_word_end,
  input  logic              cap_error,
  input  logic [CHAR_W-1:0] rec_char,
  output logic [CHAR_W-1:0] out_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        err_cnt
);

  localparam int unsigned PRESC_W = 16;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PULSES_PER_UNIT - 1);
  localparam logic [CNT_W-1:0]   FIFO_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef MORSE_CTRL_AUTOSPACE_EN
  localparam logic [CHAR_W-1:0] SPACE_CODE = CHAR_W'(`CHAR_CODE_SPACE);
  typedef enum logic [2:0] {IDLE, ARM, RUN, COMMIT, SPACE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARM, RUN, COMMIT, ERR} state_t;
`endif

  state_t              state, next_state;
  logic [PRESC_W-1:0]  presc, presc_next;
  logic [CHAR_W-1:0]   char_q;
  logic                take_ev;
  logic                push;
  logic [CHAR_W-1:0]   push_data;
  logic                pop;
  logic                wr_ok;
  logic [CHAR_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count, count_next;
`ifdef MORSE_CTRL_AUTOSPACE_EN
  logic                word_q;
`endif

  // Next-state and push decode; shutdown has priority over capture events
  always_comb begin
    next_state = state;
    take_ev    = 1'b0;
    push       = 1'b0;
    push_data  = char_q;
    case (state)
      IDLE: if (en) next_state = ARM;
      ARM:  next_state = en ? RUN : IDLE;
      RUN: begin
        if (!en) begin
          next_state = IDLE;
        end else if (cap_ceo && cap_error) begin
          next_state = ERR;
        end else if (cap_ceo && (cap_char_end || cap_word_end)) begin
          next_state = COMMIT;
          take_ev    = 1'b1;
        end
      end
      COMMIT: begin
        push       = 1'b1;
        next_state = en ? ARM : IDLE;
`ifdef MORSE_CTRL_AUTOSPACE_EN
        if (word_q) next_state = SPACE;
`endif
      end
`ifdef MORSE_CTRL_AUTOSPACE_EN
      SPACE: begin
        push       = 1'b1;
        push_data  = SPACE_CODE;
        next_state = en ? ARM : IDLE;
      end
`endif
      ERR: begin
        push       = 1'b1;
        push_data  = ERR_CODE;
        next_state = en ? ARM : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Prescaler only advances in RUN; anywhere else it sits at zero
  always_comb begin
    presc_next = '0;
    if (state == RUN && presc != PRESC_LAST) presc_next = presc + PRESC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      char_q    <= '0;
      cap_start <= 1'b0;
      cap_ce    <= 1'b0;
      busy      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= next_state;
      presc     <= presc_next;
      cap_start <= (next_state == ARM);
      cap_ce    <= (next_state == RUN) && (presc_next == PRESC_LAST);
      busy      <= (next_state != IDLE);
      if (take_ev) char_q <= rec_char;
      if (state == ERR && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef MORSE_CTRL_AUTOSPACE_EN
  always_ff @(posedge clk) begin
    if (rst)          word_q <= 1'b0;
    else if (take_ev) word_q <= cap_word_end;
  end
`endif

  // Output FIFO: a full push is accepted only when a pop frees a slot the same cycle
  assign pop   = out_valid && out_ready;
  assign wr_ok = push && ((count != FIFO_FULL) || pop);

  always_comb begin
    count_next = count + CNT_W'(wr_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_next;
      out_valid <= (count_next != '0);
      if (push && !wr_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_data;
  end

  assign out_char = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_morse_capture_ctrl.sv
// Directed bench for morse_capture_ctrl: vector table for reset/enable/commit,
// hand-written sequences for word gap, errors, FIFO full, disable and reset.
`ifndef CHAR_CODE_SPACE
`define CHAR_CODE_SPACE 5'h1E
`endif

module tb_morse_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, cap_ceo, cap_char_end, cap_word_end, cap_error, out_ready;
  logic [4:0] rec_char;
  logic       cap_start, cap_ce, out_valid, busy, overflow;
  logic [4:0] out_char;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] SP  = `CHAR_CODE_SPACE;
  localparam logic [4:0] ERC = 5'h1F;

  morse_capture_ctrl #(
    .PULSES_PER_UNIT(4),
    .CHAR_W(5),
    .ERR_CODE(5'h1F),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .cap_start(cap_start), .cap_ce(cap_ce), .cap_ceo(cap_ceo),
    .cap_char_end(cap_char_end), .cap_word_end(cap_word_end), .cap_error(cap_error),
    .rec_char(rec_char), .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overflow(overflow), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // in = {rst,en,ceo,char_end,word_end,error,ready}; exp = {cap_start,cap_ce,busy,out_valid}
  typedef struct {
    logic [6:0] in;
    logic [4:0] ch;
    logic [3:0] exp;
    logic [4:0] oc;
  } vec_t;

  vec_t vt [15];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ev(input logic ce, input logic we, input logic er, input logic [4:0] ch);
    cap_ceo = 1'b1; cap_char_end = ce; cap_word_end = we; cap_error = er; rec_char = ch;
  endtask

  task automatic clr_ev;
    cap_ceo = 1'b0; cap_char_end = 1'b0; cap_word_end = 1'b0; cap_error = 1'b0; rec_char = 5'h00;
  endtask

  // Reset, enable, and land in the first RUN cycle
  task automatic start_run;
    clr_ev(); out_ready = 1'b0; rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1;
    tick();
    tick();
  endtask

  task automatic send_char(input logic [4:0] ch);
    set_ev(1'b1, 1'b0, 1'b0, ch);
    tick();
    clr_ev();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] exp_q [4];

    vt[0]  = '{7'b1000000, 5'h00, 4'b0000, 5'h00};
    vt[1]  = '{7'b0100000, 5'h00, 4'b1010, 5'h00};
    vt[2]  = '{7'b0100000, 5'h00, 4'b0010, 5'h00};
    vt[3]  = '{7'b0100000, 5'h00, 4'b0010, 5'h00};
    vt[4]  = '{7'b0100000, 5'h00, 4'b0010, 5'h00};
    vt[5]  = '{7'b0100000, 5'h00, 4'b0110, 5'h00};
    vt[6]  = '{7'b0100000, 5'h00, 4'b0010, 5'h00};
    vt[7]  = '{7'b0100000, 5'h00, 4'b0010, 5'h00};
    vt[8]  = '{7'b0100000, 5'h00, 4'b0010, 5'h00};
    vt[9]  = '{7'b0100000, 5'h00, 4'b0110, 5'h00};
    vt[10] = '{7'b0111000, 5'h0A, 4'b0010, 5'h00};
    vt[11] = '{7'b0100000, 5'h00, 4'b1011, 5'h0A};
    vt[12] = '{7'b0100000, 5'h00, 4'b0011, 5'h0A};
    vt[13] = '{7'b0100001, 5'h00, 4'b0010, 5'h00};
    vt[14] = '{7'b0100000, 5'h00, 4'b0010, 5'h00};

    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    clr_ev();

    for (int i = 0; i < 15; i++) begin
      {rst, en, cap_ceo, cap_char_end, cap_word_end, cap_error, out_ready} = vt[i].in;
      rec_char = vt[i].ch;
      tick();
      chk($sformatf("v%0d cap_start", i), 32'(cap_start), 32'(vt[i].exp[3]));
      chk($sformatf("v%0d cap_ce", i),    32'(cap_ce),    32'(vt[i].exp[2]));
      chk($sformatf("v%0d busy", i),      32'(busy),      32'(vt[i].exp[1]));
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].exp[0]));
      chk($sformatf("v%0d out_char", i),  32'(out_char),  32'(vt[i].oc));
      chk($sformatf("v%0d err_cnt", i),   32'(err_cnt),   0);
      chk($sformatf("v%0d overflow", i),  32'(overflow),  0);
    end
    out_ready = 1'b0;

    // Word gap
    set_ev(1'b0, 1'b1, 1'b0, 5'h03);
    tick();
    clr_ev();
    tick();
    chk("word out_valid", 32'(out_valid), 1);
    chk("word out_char", 32'(out_char), 32'(5'h03));
`ifdef MORSE_CTRL_AUTOSPACE_EN
    chk("word space state no start", 32'(cap_start), 0);
    tick();
    chk("word rearm", 32'(cap_start), 1);
    out_ready = 1'b1;
    tick();
    chk("word 2nd valid", 32'(out_valid), 1);
    chk("word 2nd space", 32'(out_char), 32'(SP));
    tick();
    chk("word drained", 32'(out_valid), 0);
`else
    chk("word rearm", 32'(cap_start), 1);
    out_ready = 1'b1;
    tick();
    chk("word single entry", 32'(out_valid), 0);
`endif
    out_ready = 1'b0;

    // Error with simultaneous char_end
    set_ev(1'b1, 1'b0, 1'b1, 5'h0A);
    tick();
    chk("err busy", 32'(busy), 1);
    clr_ev();
    tick();
    chk("err cnt 1", 32'(err_cnt), 1);
    chk("err valid", 32'(out_valid), 1);
    chk("err code", 32'(out_char), 32'(ERC));
    chk("err rearm", 32'(cap_start), 1);
    out_ready = 1'b1;
    tick();
    chk("err single entry", 32'(out_valid), 0);

    for (int k = 0; k < 299; k++) begin
      set_ev(1'b0, 1'b0, 1'b1, 5'h00);
      tick();
      clr_ev();
      tick();
      tick();
    end
    chk("err saturate", 32'(err_cnt), 255);
    chk("err no overflow", 32'(overflow), 0);
    chk("err drained", 32'(out_valid), 0);
    out_ready = 1'b0;

    // FIFO full, push+pop while full, then drop
    start_run();
    chk("rst err_cnt", 32'(err_cnt), 0);
    for (int k = 1; k <= 4; k++) send_char(5'(k));
    chk("full no overflow", 32'(overflow), 0);
    chk("full head", 32'(out_char), 1);
    set_ev(1'b1, 1'b0, 1'b0, 5'h05);
    tick();
    clr_ev();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("full pushpop head", 32'(out_char), 2);
    chk("full pushpop overflow", 32'(overflow), 0);
    tick();
    send_char(5'h06);
    chk("full drop overflow", 32'(overflow), 1);
    exp_q[0] = 5'h02; exp_q[1] = 5'h03; exp_q[2] = 5'h04; exp_q[3] = 5'h05;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain valid %0d", k), 32'(out_valid), 1);
      chk($sformatf("drain char %0d", k), 32'(out_char), 32'(exp_q[k]));
      tick();
    end
    chk("drain empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    // en=0 in RUN where cap_ce would fire, with a pending event
    start_run();
    tick();
    tick();
    en = 1'b0;
    set_ev(1'b1, 1'b0, 1'b0, 5'h07);
    tick();
    chk("dis busy", 32'(busy), 0);
    chk("dis cap_ce", 32'(cap_ce), 0);
    clr_ev();
    tick();
    chk("dis event dropped", 32'(out_valid), 0);
    chk("dis stays idle", 32'(busy), 0);

    // en=0 during COMMIT
    en = 1'b1;
    tick();
    chk("reen start", 32'(cap_start), 1);
    tick();
    set_ev(1'b1, 1'b0, 1'b0, 5'h09);
    tick();
    clr_ev();
    en = 1'b0;
    tick();
    chk("commit dis busy", 32'(busy), 0);
    chk("commit dis no start", 32'(cap_start), 0);
    chk("commit dis valid", 32'(out_valid), 1);
    chk("commit dis char", 32'(out_char), 9);

    // rst while a push is pending
    start_run();
    set_ev(1'b0, 1'b1, 1'b0, 5'h04);
    tick();
    clr_ev();
`ifdef MORSE_CTRL_AUTOSPACE_EN
    tick();
    chk("space state valid", 32'(out_valid), 1);
`endif
    rst = 1'b1;
    en  = 1'b0;
    tick();
    chk("rst mid empty", 32'(out_valid), 0);
    chk("rst mid busy", 32'(busy), 0);
    rst = 1'b0;
    tick();
    chk("rst mid no push", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_capture_ctrl.md
# morse_capture_ctrl

Sequencer for the Morse receive path. It generates the unit-rate clock enable for the character capture block from the system clock, re-arms capture after every character, and latches each recognized character (or an error code) into a 4-entry output FIFO. With autospace enabled it also inserts a space code on word gaps. It sits between the capture/recognize pair and the display/consumer logic.

## Interface
Parameters:
- PULSES_PER_UNIT, 4: system clocks per Morse unit tick; legal range 1..65535.
- ERR_CODE, 5'h1F: value pushed on a capture error (CHAR_W bits).
- FIFO_DEPTH, 4: output FIFO entries; fixed power of two.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; level-sensitive.
- cap_start  out  1  one-cycle restart pulse to the capture block.
- cap_ce  out  1  unit-tick clock enable to the capture block.
- cap_ceo  in  1  capture output qualifier; event inputs are sampled only when this is 1.
- cap_char_end  in  1  character gap detected.
- cap_word_end  in  1  word gap detected; implies char end.
- cap_error  in  1  malformed symbol.
- rec_char  in  CHAR_W  recognizer output, valid when cap_ceo=1.
- out_char  out  CHAR_W  FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer pop.
- busy  out  1  state is not IDLE.
- overflow  out  1  sticky; a push was dropped.
- err_cnt  out  8  count of errors, saturating at 255.

## Operation
- States: IDLE, ARM, RUN, COMMIT, SPACE, ERR.
- IDLE: cap_ce=0. en=1 moves to ARM.
- ARM: cap_start=1 for exactly one cycle. The prescaler clears to 0. Next state is RUN.
- RUN: the prescaler counts 0..PULSES_PER_UNIT-1 and wraps. cap_ce=1 on the cycle the count equals PULSES_PER_UNIT-1. If PULSES_PER_UNIT=1, cap_ce=1 every RUN cycle.
- Event priority in RUN when cap_ceo=1: cap_error, then cap_word_end/cap_char_end.
  - error → ERR.
  - char_end or word_end → COMMIT. rec_char is latched in this same cycle, and a word flag is latched from cap_word_end.
- COMMIT: push the latched char. Then go to SPACE if the word flag is set and autospace is compiled in; otherwise go to ARM.
- SPACE: push `CHAR_CODE_SPACE`, then go to ARM.
- ERR: push ERR_CODE and increment err_cnt (saturating), then go to ARM.
- en=0 handling:
  - Sampled in ARM or RUN, it moves the FSM to IDLE next cycle; a pending event on that same cycle is discarded.
  - COMMIT, SPACE and ERR always complete their push; the FSM then goes to IDLE instead of ARM if en=0.
- FIFO:
  - Pop happens when out_valid & out_ready.
  - A push while full with no simultaneous pop is dropped and sets overflow.
  - Push and pop in the same cycle while full are both accepted; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle while empty: the push is accepted and no pop occurs.
- Reset values:
  - FSM=IDLE, prescaler=0, FIFO empty.
  - out_valid=0, out_char=0, cap_start=0, cap_ce=0.
  - busy=0, overflow=0, err_cnt=0.
  - rst mid-operation aborts any push in progress.

## Timing
- All outputs are registered except out_char, which is the combinational FIFO head read.
- en rises at cycle t (sampled at IDLE) → ARM at t+1 with cap_start=1 → RUN at t+2. The first cap_ce is at t+2+PULSES_PER_UNIT-1.
- Event sampled at cycle n → COMMIT/ERR at n+1 (push occurs there) → out_valid=1 at n+2 if the FIFO was empty → ARM at n+2 (no space) or n+3 (with space). The space entry is visible at n+3.
- Capture events arriving outside RUN are ignored.
- cap_ce is never asserted outside RUN.

## Configuration
- MORSE_CTRL_AUTOSPACE_EN defined: a word_end event pushes the char followed by `CHAR_CODE_SPACE` (two entries). The SPACE state exists.
- Not defined: SPACE is unreachable and removed. A word_end event is treated exactly like char_end and pushes one entry.

## Test plan
- Reset / enable: PULSES_PER_UNIT=4; assert rst, then en=1.
  - Immediately after reset, all outputs are at their reset values.
  - Then cap_start is a one-cycle pulse, and cap_ce pulses every 4th cycle starting 3 cycles into RUN.
- Character commit: drive cap_ceo=1, cap_char_end=1, rec_char=5'h0A in RUN.
  - out_valid=1 two cycles later with out_char=5'h0A.
  - cap_start pulses again.
  - Exactly one FIFO entry.
- Word end with autospace: drive word_end with rec_char=5'h03.
  - FIFO holds 5'h03 then `CHAR_CODE_SPACE`.
  - Without the macro, FIFO holds only 5'h03.
- Error path: error and char_end asserted together.
  - Only ERR_CODE is pushed and err_cnt=1.
  - After 300 errors, err_cnt stays 255.
- FIFO full: out_ready=0; send 5 characters.
  - The first 4 are retained in order, the 5th is dropped, and overflow=1.
  - A full-FIFO push with simultaneous pop is accepted and overflow is unchanged.
- Disable / reset mid-operation:
  - en=0 during RUN → IDLE next cycle and cap_ce=0.
  - en=0 during COMMIT → the push completes, then IDLE.
  - rst during SPACE → FIFO empty and no space entry.
